// File: rtl/expr_dp_pkg.sv
// expr_dp_pkg: shared widths and scheduler state encoding for the expression datapath scheduler.
package expr_dp_pkg;
  localparam int OP_W  = 12;
  localparam int RES_W = 17;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} sched_state_e;
endpackage

// File: rtl/expr_dp_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after i_last.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx
);
  // Walk from the farthest slot to the nearest so the nearest valid one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_en && i_req[(int'(i_last) + i) % NUM_REQ]) begin
        o_grant = NUM_REQ'(1) << ((int'(i_last) + i) % NUM_REQ);
        o_idx   = IW'((int'(i_last) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/expr_dp_scheduler.sv
// expr_dp_scheduler: round-robin time-sharing of one multicycle expression datapath
// among NUM_REQ requesters, with a tagged, backpressured response channel.
module expr_dp_scheduler
  import expr_dp_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*OP_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RES_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [OP_W-1:0]            dp_in_data,
  input  logic [RES_W-1:0]           dp_out_data,
  output logic                       busy,
  output logic [CNT_W-1:0]           done_count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DP_LATENCY + 1);
  sched_state_e       r_state;
  logic [IW-1:0]      r_last, r_tag, w_idx;
  logic [CW-1:0]      r_cnt;
  logic [OP_W-1:0]    r_op;
  logic [RES_W-1:0]   r_res;
  logic [CNT_W-1:0]   r_done;
  logic [NUM_REQ-1:0] w_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_last  (r_last),
    .i_en    (en && r_state == IDLE),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready  = w_grant;
  assign rsp_valid  = r_state == RESP;
  assign busy       = r_state != IDLE;
  assign rsp_data   = r_res;
  assign rsp_id     = r_tag;
  assign dp_in_data = r_op;
  assign done_count = r_done;

  // r_op is never cleared between operations so the datapath input stays quiet in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_tag   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_grant) begin
          r_op    <= req_data[OP_W*int'(w_idx) +: OP_W];
          r_tag   <= w_idx;
          r_last  <= w_idx;
          r_cnt   <= CW'(DP_LATENCY);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res   <= dp_out_data;
            r_state <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          r_done  <= r_done + CNT_W'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_expr_dp_scheduler.sv
// tb_expr_dp_scheduler: vector table, corner-case sequences and a randomized run against a
// transaction-timeline model of the scheduler; a second instance exercises DP_LATENCY=3.
module tb_expr_dp_scheduler;
  localparam int N = 4;
  localparam int LAT = 1;

  logic clk = 0, rst_n = 1, en = 0, rsp_ready = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*12-1:0] req_data = '0;
  logic rsp_valid, busy;
  logic [16:0] rsp_data, dp_out_data;
  logic [1:0] rsp_id;
  logic [11:0] dp_in_data;
  logic [15:0] done_count;

  logic [N-1:0] rv3 = '0, rr3;
  logic [N*12-1:0] rd3 = '0;
  logic v3, b3;
  logic [16:0] d3, dpo3, s1, s2;
  logic [1:0] id3;
  logic [11:0] dpi3;
  logic [15:0] c3;

  int n_checks = 0, n_err = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [47:0] data;
    logic [3:0]  g;
    logic [16:0] res;
    logic [1:0]  id;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;
  assign dp_out_data = 17'(dp_in_data) + 17'd3;
  // Slow stub: the sum only shows up two cycles after its operand changes.
  always @(posedge clk) begin
    s1 <= 17'(dpi3) + 17'd3;
    s2 <= s1;
  end
  assign dpo3 = s2;

  expr_dp_scheduler #(.NUM_REQ(N), .DP_LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .dp_in_data(dp_in_data), .dp_out_data(dp_out_data), .busy(busy),
    .done_count(done_count)
  );

  expr_dp_scheduler #(.NUM_REQ(N), .DP_LATENCY(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(rv3), .req_data(rd3),
    .req_ready(rr3), .rsp_valid(v3), .rsp_ready(rsp_ready), .rsp_data(d3),
    .rsp_id(id3), .dp_in_data(dpi3), .dp_out_data(dpo3), .busy(b3),
    .done_count(c3)
  );

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [3:0] rv, input int last);
    for (int i = 1; i <= N; i++) if (rv[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  initial begin
    int m_last, m_gcyc, m_id, g;
    bit m_free, m_pend;
    logic [11:0] m_op;
    logic [16:0] m_res;
    logic [15:0] m_done;
    tbl[0] = '{4'hF, 48'h004003002001, 4'b0001, 17'h004, 2'd0};
    tbl[1] = '{4'hF, 48'h004003002001, 4'b0010, 17'h005, 2'd1};
    tbl[2] = '{4'hF, 48'h004003002001, 4'b0100, 17'h006, 2'd2};
    tbl[3] = '{4'hF, 48'h004003002001, 4'b1000, 17'h007, 2'd3};
    tbl[4] = '{4'hF, 48'h004003002001, 4'b0001, 17'h004, 2'd0};
    tbl[5] = '{4'b0100, 48'h0040A5002001, 4'b0100, 17'h0A8, 2'd2};
    tbl[6] = '{4'b1001, 48'hFFF0A5002001, 4'b1000, 17'h1002, 2'd3};
    tbl[7] = '{4'b1001, 48'hFFF0A5002001, 4'b0001, 17'h004, 2'd0};
    tbl[8] = '{4'b0110, 48'hFFF0A5002001, 4'b0010, 17'h005, 2'd1};
    tbl[9] = '{4'b1000, 48'h7FF0A5002001, 4'b1000, 17'h802, 2'd3};

    #1 rst_n = 0;
    #1;
    chk("rst_req_ready", 48'(req_ready), 0);
    chk("rst_rsp_valid", 48'(rsp_valid), 0);
    chk("rst_rsp_data", 48'(rsp_data), 0);
    chk("rst_rsp_id", 48'(rsp_id), 0);
    chk("rst_dp_in", 48'(dp_in_data), 0);
    chk("rst_busy", 48'(busy), 0);
    chk("rst_done", 48'(done_count), 0);
    @(negedge clk);
    rst_n = 1; en = 1; rsp_ready = 1;

    // DP_LATENCY=3 instance: only the settled sum may be captured
    tick; rv3 = 4'b0010; rd3 = 48'h0000003A0000;
    smp; chk("l3_grant", 48'(rr3), 48'b0010);
    for (int c = 1; c <= 3; c++) begin
      tick; rv3 = '0;
      smp; chk("l3_wait_valid", 48'(v3), 0);
    end
    chk("l3_dp_in", 48'(dpi3), 48'h3A0);
    tick; smp;
    chk("l3_rsp_valid", 48'(v3), 1);
    chk("l3_rsp_data", 48'(d3), 48'h3A3);
    chk("l3_rsp_id", 48'(id3), 1);
    tick; smp; chk("l3_done", 48'(c3), 1);

    // Table: round-robin order, single request, wrap and operand extremes
    for (int i = 0; i < 10; i++) begin
      tick; req_valid = tbl[i].rv; req_data = tbl[i].data;
      smp;
      chk("tbl_grant", 48'(req_ready), 48'(tbl[i].g));
      chk("tbl_idle_busy", 48'(busy), 0);
      tick; smp;
      chk("tbl_wait_ready", 48'(req_ready), 0);
      chk("tbl_wait_rsp", 48'(rsp_valid), 0);
      chk("tbl_dp_in", 48'(dp_in_data), 48'(tbl[i].data[12*int'(tbl[i].id) +: 12]));
      tick; smp;
      chk("tbl_rsp_valid", 48'(rsp_valid), 1);
      chk("tbl_rsp_data", 48'(rsp_data), 48'(tbl[i].res));
      chk("tbl_rsp_id", 48'(rsp_id), 48'(tbl[i].id));
      chk("tbl_done", 48'(done_count), 48'(i));
    end

    // Backpressure: response held stable, regrant one cycle after handshake
    tick; rsp_ready = 0; req_valid = 4'b0100; req_data = 48'h000123000000;
    smp; chk("bp_grant", 48'(req_ready), 48'b0100);
    tick; tick;
    for (int k = 0; k < 5; k++) begin
      smp;
      chk("bp_valid", 48'(rsp_valid), 1);
      chk("bp_data", 48'(rsp_data), 48'h126);
      chk("bp_id", 48'(rsp_id), 2);
      chk("bp_no_grant", 48'(req_ready), 0);
      tick;
    end
    rsp_ready = 1;
    smp; chk("bp_hs_valid", 48'(rsp_valid), 1); chk("bp_hs_done", 48'(done_count), 10);
    tick; smp;
    chk("bp_after_valid", 48'(rsp_valid), 0);
    chk("bp_regrant", 48'(req_ready), 48'b0100);
    chk("bp_after_done", 48'(done_count), 11);
    tick; tick; smp; chk("bp2_data", 48'(rsp_data), 48'h126);

    // Enable gating
    tick; en = 0; req_valid = 4'hF; req_data = 48'h004003002001;
    for (int k = 0; k < 10; k++) begin
      smp;
      chk("en_off_ready", 48'(req_ready), 0);
      chk("en_off_busy", 48'(busy), 0);
      tick;
    end
    en = 1;
    smp; chk("en_on_grant", 48'(req_ready), 48'b1000);
    tick; en = 0;
    smp; chk("en_drop_busy", 48'(busy), 1);
    tick; smp;
    chk("en_drop_rsp", 48'(rsp_valid), 1);
    chk("en_drop_data", 48'(rsp_data), 48'h007);
    chk("en_drop_id", 48'(rsp_id), 3);
    tick; smp;
    chk("en_drop_done", 48'(done_count), 13);
    for (int k = 0; k < 3; k++) begin
      chk("en_drop_nogrant", 48'(req_ready), 0);
      chk("en_drop_idle", 48'(busy), 0);
      tick; smp;
    end

    // Asynchronous reset while requester 3 is in flight
    tick; en = 1; req_valid = 4'b1000;
    smp; chk("rst_mid_grant", 48'(req_ready), 48'b1000);
    tick; rst_n = 0;
    #1;
    chk("rst_mid_busy", 48'(busy), 0);
    chk("rst_mid_dp_in", 48'(dp_in_data), 0);
    chk("rst_mid_rsp_id", 48'(rsp_id), 0);
    chk("rst_mid_rsp_data", 48'(rsp_data), 0);
    chk("rst_mid_done", 48'(done_count), 0);
    tick; smp;
    chk("rst_mid_rsp", 48'(rsp_valid), 0);
    req_valid = 4'hF; rst_n = 1;
    #1; chk("rst_rel_grant", 48'(req_ready), 48'b0001);
    tick; smp;
    chk("rst_rel_wait", 48'(rsp_valid), 0);
    chk("rst_rel_dp_in", 48'(dp_in_data), 48'h001);
    tick; smp;
    chk("rst_rel_rsp", 48'(rsp_valid), 1);
    chk("rst_rel_data", 48'(rsp_data), 48'h004);
    chk("rst_rel_id", 48'(rsp_id), 0);
    tick; req_valid = '0;
    smp; chk("rst_rel_done", 48'(done_count), 1);

    // Randomized run against a timeline model
    tick; rst_n = 0;
    @(negedge clk); rst_n = 1;
    m_free = 1; m_last = N - 1; m_done = 0; m_op = 0; m_res = 0; m_id = 0; m_gcyc = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick;
      en = ($urandom_range(7) != 0);
      req_valid = 4'($urandom_range(15));
      req_data = 48'({$urandom(), $urandom()});
      rsp_ready = 1'($urandom_range(1));
      smp;
      g = (m_free && en && |req_valid) ? rr_pick(req_valid, m_last) : -1;
      m_pend = !m_free && (cyc - m_gcyc >= LAT + 1);
      chk("rnd_grant", 48'(req_ready), (g < 0) ? 48'd0 : (48'd1 << g));
      chk("rnd_rsp_valid", 48'(rsp_valid), 48'(m_pend));
      chk("rnd_busy", 48'(busy), 48'(!m_free));
      chk("rnd_done", 48'(done_count), 48'(m_done));
      chk("rnd_dp_in", 48'(dp_in_data), 48'(m_op));
      if (m_pend) begin
        chk("rnd_rsp_data", 48'(rsp_data), 48'(m_res));
        chk("rnd_rsp_id", 48'(rsp_id), 48'(m_id));
      end
      if (g >= 0) begin
        m_free = 0; m_gcyc = cyc; m_last = g; m_id = g;
        m_op = req_data[12*g +: 12];
        m_res = 17'(m_op) + 17'd3;
      end else if (m_pend && rsp_ready) begin
        m_free = 1; m_done++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/expr_dp_scheduler.md
Name: expr_dp_scheduler

Overview:
- Time-shares one combinational expression datapath (12-bit operand in, 17-bit result out) among NUM_REQ requesters.
- Each requester has a valid/ready request channel. Requests are granted round-robin.
- The granted operand is held stable on the datapath for a configurable number of settle cycles, then the result is captured.
- The result is returned on a single tagged response channel with backpressure.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DP_LATENCY, 1: settle cycles the operand is held before the result is captured (>=1; the datapath is a multicycle path).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  when low, no new grants are made; an operation already in flight still completes.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*12  packed operands; requester i uses bits [12*i+11 : 12*i].
- req_ready  output  NUM_REQ  one-hot grant pulse, accept strobe.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  17  captured datapath result.
- rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
- dp_in_data  output  12  operand driven to the shared datapath.
- dp_out_data  input  17  datapath result (combinational from dp_in_data).
- busy  output  1  high in any state other than IDLE.
- done_count  output  CNT_W  number of responses accepted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs are 0: req_ready, rsp_valid, rsp_data, rsp_id, dp_in_data, busy, done_count.
  - last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
  - Reset asserted mid-operation abandons the operation. No response is issued for it.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If en=1 and req_valid is nonzero, the grant goes to the first valid index searching upward from last_grant+1, with wrap.
  - req_ready[g]=1 combinationally in that cycle only. All other bits are 0.
  - On the clock edge: op_reg<=req_data[g], tag<=g, last_grant<=g, cnt<=DP_LATENCY, state goes to WAIT.
  - If en=0 or no request is valid, req_ready=0 and the FSM stays in IDLE.
- WAIT:
  - dp_in_data=op_reg, held constant for the whole state.
  - cnt decrements each cycle.
  - In the cycle where cnt==1: res_reg<=dp_out_data, state goes to RESP.
  - Changes on en or req_valid are ignored. req_ready=0.
- RESP:
  - rsp_valid=1, rsp_data=res_reg, rsp_id=tag. All three are held stable until handshake.
  - On rsp_valid&&rsp_ready: done_count increments (with wrap), state goes to IDLE.
  - There is no same-cycle regrant. The next grant is no earlier than the following cycle.
- dp_in_data keeps its last operand while in IDLE. It is not zeroed.
- Latency:
  - From the grant cycle to first rsp_valid is DP_LATENCY+1 cycles.
  - Minimum issue interval is DP_LATENCY+2 cycles when rsp_ready is held at 1.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- A requester that drops req_valid before being granted is simply skipped. Requesters must not drop valid after the ready pulse; the transfer is already complete.
- Widths: operands are 12 bits and results 17 bits. There is no truncation or extension inside the block.

Decomposition:
- Shared package expr_dp_pkg contains:
  - OP_W=12 and RES_W=17.
  - The state enum sched_state_e {IDLE, WAIT, RESP}.
- Sub-module rr_arbiter(NUM_REQ):
  - Inputs: req vector, last_grant pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; it is reused elsewhere.

Test Plan:
- Bench stub for all scenarios: dp_out_data = dp_in_data + 3. DP_LATENCY=1 unless stated otherwise.
- Single request: req_valid=4'b0100, req_data[2]=0x0A5, rsp_ready=1.
  - Expect req_ready=4'b0100 for one cycle.
  - Expect rsp_valid 2 cycles later with rsp_data=0x000A8, rsp_id=2.
  - After handshake, expect done_count=1.
- Round-robin: all four requesters valid continuously, operands 0x001..0x004, rsp_ready=1.
  - Expect grant order 0,1,2,3,0.
  - Expect responses 0x004, 0x005, 0x006, 0x007, spaced 3 cycles apart.
- Backpressure: after a response is presented, hold rsp_ready=0 for 5 cycles.
  - rsp_valid, rsp_data and rsp_id stay stable.
  - req_ready stays 0.
  - The handshake occurs on the cycle rsp_ready rises.
  - The next grant comes one cycle later.
- Enable gating:
  - With en=0 and all requesters valid: no req_ready for 10 cycles.
  - Drop en to 0 during WAIT: the in-flight response still completes, and no further grants follow.
- Reset mid-WAIT: assert rst_n=0 asynchronously while a requester-3 operation is in flight.
  - All outputs go to 0 immediately.
  - No response is issued for the abandoned operation.
  - After release with all requesters valid, the first grant goes to requester 0.
- DP_LATENCY=3: stub changes dp_out_data only 2 cycles after dp_in_data changes.
  - Captured rsp_data is the settled value.
  - rsp_valid appears 4 cycles after the grant.
